// File: rtl/tdm_demux4_pkg.sv
// Shared constants for the 4-slot TDM demultiplexer: FSM encodings and slot geometry.
package tdm_demux4_pkg;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int SLOT_CNT = 4;
  localparam int SLOT_W   = 2;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index, wrap and FrameSync miss tracking for tdm_demux4; Sel is registered,
// event flags are combinational decodes of the current sample for the parent FSM.
module tdm_slot_counter
  import tdm_demux4_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              sync_i,
  input  logic              locked_i,
  output logic [SLOT_W-1:0] sel_o,
  output logic              lose_lock_o,
  output logic              mis_sync_o,
  output logic              frame_end_o
);

  localparam int MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  logic [SLOT_W-1:0] sel_q, sel_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              slot0;

  assign slot0       = (sel_q == '0);
  assign lose_lock_o = enable_i && locked_i && !sync_i && slot0 &&
                       ((int'(miss_q) + 1) >= MISS_MAX);
  assign mis_sync_o  = enable_i && locked_i && sync_i && !slot0;
  assign frame_end_o = enable_i && locked_i && !sync_i &&
                       (sel_q == SLOT_W'(SLOT_CNT - 1));
  assign sel_o       = sel_q;

  always_comb begin
    sel_d  = sel_q;
    miss_d = miss_q;
    if (enable_i) begin
      if (sync_i) begin
        // Any accepted FrameSync restarts the frame at slot 1, locked or not.
        sel_d  = SLOT_W'(1);
        miss_d = '0;
      end else if (locked_i) begin
        if (lose_lock_o) begin
          sel_d  = '0;
          miss_d = '0;
        end else begin
          sel_d = sel_q + SLOT_W'(1);
          if (slot0) miss_d = miss_q + MISS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      miss_q <= '0;
    end else begin
      sel_q  <= sel_d;
      miss_q <= miss_d;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with FrameSync lock FSM; Out0-Out3 update together one edge
// after the slot-3 sample, Valid pulses that cycle; Enable low stalls everything.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MISS_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  In,
  input  logic              FrameSync,
  input  logic              Enable,
  output logic [WIDTH-1:0]  Out0,
  output logic [WIDTH-1:0]  Out1,
  output logic [WIDTH-1:0]  Out2,
  output logic [WIDTH-1:0]  Out3,
  output logic              Valid,
  output logic [SLOT_W-1:0] Sel,
  output logic              Locked,
  output logic              SyncErr
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic             valid_q, valid_d, sync_err_q, sync_err_d;
  logic             lose_lock, mis_sync, frame_end;

  tdm_slot_counter #(.MISS_MAX(MISS_MAX)) u_slot_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (Enable),
    .sync_i      (FrameSync),
    .locked_i    (state_q == ST_LOCKED),
    .sel_o       (Sel),
    .lose_lock_o (lose_lock),
    .mis_sync_o  (mis_sync),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d    = state_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out3_d     = out3_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    if (Enable) begin
      if (state_q == ST_HUNT) begin
        if (FrameSync) begin
          sh0_d   = In;
          state_d = ST_LOCKED;
        end
      end else if (FrameSync) begin
        // Early FrameSync: stale slots 1-2 are overwritten before the next output load.
        sh0_d      = In;
        sync_err_d = mis_sync;
      end else if (lose_lock) begin
        state_d = ST_HUNT;
      end else if (frame_end) begin
        out0_d  = sh0_q;
        out1_d  = sh1_q;
        out2_d  = sh2_q;
        out3_d  = In;
        valid_d = 1'b1;
      end else begin
        case (Sel)
          2'd0:    sh0_d = In;
          2'd1:    sh1_d = In;
          default: sh2_d = In;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out3_q     <= out3_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign Out0    = out0_q;
  assign Out1    = out1_q;
  assign Out2    = out2_q;
  assign Out3    = out3_q;
  assign Valid   = valid_q;
  assign SyncErr = sync_err_q;
  assign Locked  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4, MISS_MAX=2) with hand-computed expectations.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [3:0] In;
  logic       FrameSync;
  logic       Enable;
  logic [3:0] Out0, Out1, Out2, Out3;
  logic       Valid;
  logic [1:0] Sel;
  logic       Locked;
  logic       SyncErr;

  int checks   = 0;
  int failures = 0;

  tdm_demux4 #(.WIDTH(4), .MISS_MAX(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (In),
    .FrameSync (FrameSync),
    .Enable    (Enable),
    .Out0      (Out0),
    .Out1      (Out1),
    .Out2      (Out2),
    .Out3      (Out3),
    .Valid     (Valid),
    .Sel       (Sel),
    .Locked    (Locked),
    .SyncErr   (SyncErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
  task automatic step(input logic en, input logic fs, input logic [3:0] d);
    Enable    = en;
    FrameSync = fs;
    In        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] sel, input logic lk,
                        input logic vld, input logic serr);
    chk({tag, ".sel"},    32'(Sel),     32'(sel));
    chk({tag, ".locked"}, 32'(Locked),  32'(lk));
    chk({tag, ".valid"},  32'(Valid),   32'(vld));
    chk({tag, ".syncerr"},32'(SyncErr), 32'(serr));
  endtask

  task automatic chk_out(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    chk({tag, ".out0"}, 32'(Out0), 32'(a));
    chk({tag, ".out1"}, 32'(Out1), 32'(b));
    chk({tag, ".out2"}, 32'(Out2), 32'(c));
    chk({tag, ".out3"}, 32'(Out3), 32'(d));
  endtask

  initial begin
    rst_n     = 1'b0;
    Enable    = 1'b0;
    FrameSync = 1'b0;
    In        = 4'h0;
    #2;
    chk_st("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 0,1,0,1 with FrameSync on slot 0
    step(1'b1, 1'b1, 4'h0); chk_st("f1.s0", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h1); chk_st("f1.s1", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0); chk_st("f1.s2", 2'd3, 1'b1, 1'b0, 1'b0);
    chk_out("f1.pre", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h1); chk_st("f1.s3", 2'd0, 1'b1, 1'b1, 1'b0);
    chk_out("f1", 4'h0, 4'h1, 4'h0, 4'h1);
    step(1'b0, 1'b0, 4'h7); chk_st("f1.idle", 2'd0, 1'b1, 1'b0, 1'b0);

    // Hunt: unsynced samples discarded, then frame 1,0,0,1
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h1); chk_st("hunt.drop", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    chk_out("hunt.drop", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 4'h1); chk_st("f2.s0", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0); chk_st("f2.s1", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0); chk_st("f2.s2", 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h1); chk_st("f2.s3", 2'd0, 1'b1, 1'b1, 1'b0);
    chk_out("f2", 4'h1, 4'h0, 4'h0, 4'h1);

    // Early FrameSync at Sel=2 restarts the frame
    step(1'b1, 1'b1, 4'hA); chk_st("se.s0", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'hB); chk_st("se.s1", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hC); chk_st("se.err", 2'd1, 1'b1, 1'b0, 1'b1);
    chk_out("se.hold", 4'h1, 4'h0, 4'h0, 4'h1);
    step(1'b1, 1'b0, 4'hD); chk_st("se.s1b", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'hE); chk_st("se.s2b", 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'hF); chk_st("se.s3b", 2'd0, 1'b1, 1'b1, 1'b0);
    chk_out("se", 4'hC, 4'hD, 4'hE, 4'hF);

    // Enable gaps inside a frame; FrameSync while Enable=0 is ignored
    step(1'b1, 1'b1, 4'h3); chk_st("en.s0", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h9); chk_st("en.gap1", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h9); chk_st("en.gap2", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h5); chk_st("en.s1", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h9); chk_st("en.gap3", 2'd2, 1'b1, 1'b0, 1'b0);
    chk_out("en.hold", 4'hC, 4'hD, 4'hE, 4'hF);
    step(1'b1, 1'b0, 4'h6); chk_st("en.s2", 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h7); chk_st("en.s3", 2'd0, 1'b1, 1'b1, 1'b0);
    chk_out("en", 4'h3, 4'h5, 4'h6, 4'h7);

    // Missing FrameSync: first miss still outputs, second miss loses lock
    step(1'b1, 1'b0, 4'h1); chk_st("miss1.s0", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4); chk_st("miss1.s3", 2'd0, 1'b1, 1'b1, 1'b0);
    chk_out("miss1", 4'h1, 4'h2, 4'h3, 4'h4);
    step(1'b1, 1'b0, 4'h8); chk_st("miss2", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h8); chk_st("miss2.hunt", 2'd0, 1'b0, 1'b0, 1'b0);
    chk_out("miss2", 4'h1, 4'h2, 4'h3, 4'h4);

    // Asynchronous reset mid-frame at Sel=2
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b0, 4'hB); chk_st("ar.pre", 2'd2, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_st("ar.async", 2'd0, 1'b0, 1'b0, 1'b0);
    chk_out("ar.async", 4'h0, 4'h0, 4'h0, 4'h0);
    Enable = 1'b1; FrameSync = 1'b0; In = 4'hC;
    @(posedge clk);
    #1;
    chk_st("ar.held", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'hD); chk_st("ar.post", 2'd0, 1'b0, 1'b0, 1'b0);
    chk_out("ar.post", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 4'h2); chk_st("ar.relock", 2'd1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bits per time slot.
REQ-002 The block SHALL have parameter MISS_MAX, default 2, giving the number of consecutive missing FrameSync events that forces loss of lock.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port In, input, WIDTH bits: time-multiplexed sample stream.
REQ-006 The block SHALL have port FrameSync, input, 1 bit: marks the slot-0 sample of a frame.
REQ-007 The block SHALL have port Enable, input, 1 bit: sample strobe; In and FrameSync are ignored when low.
REQ-008 The block SHALL have ports Out0, Out1, Out2, Out3, output, WIDTH bits each: last complete frame, channels 0-3.
REQ-009 The block SHALL have port Valid, output, 1 bit: one-cycle pulse when Out0-Out3 are updated.
REQ-010 The block SHALL have port Sel, output, 2 bits: slot index expected for the next Enable sample.
REQ-011 The block SHALL have port Locked, output, 1 bit: high while in the LOCKED state.
REQ-012 The block SHALL have port SyncErr, output, 1 bit: one-cycle pulse when FrameSync arrives at a slot other than 0.

Function
REQ-013 The state machine SHALL have exactly two states, HUNT and LOCKED.
REQ-014 In HUNT, a sample with Enable=1 and FrameSync=0 SHALL be discarded, and Sel SHALL stay 0.
REQ-015 In HUNT, a sample with Enable=1 and FrameSync=1 SHALL be stored as slot 0, set Sel to 1, clear the miss count and enter LOCKED on that edge.
REQ-016 In LOCKED, each Enable=1 edge SHALL store In into the shadow register for slot Sel, and Sel SHALL advance modulo 4 (3 wraps to 0).
REQ-017 On the edge that stores slot 3, Out0-Out2 SHALL load shadow slots 0-2, Out3 SHALL load In directly, and Valid SHALL be 1 for exactly the following cycle.
REQ-018 Outputs SHALL never mix samples from two frames; Out0-Out3 SHALL change only together under REQ-017.
REQ-019 In LOCKED, Sel=0 with FrameSync=1 SHALL be a normal frame start and SHALL clear the miss count.
REQ-020 In LOCKED, Sel=0 with FrameSync=0 SHALL store the sample as slot 0 and increment the miss count.
REQ-021 When the miss count increment of REQ-020 reaches MISS_MAX, the block SHALL discard the sample, enter HUNT, drop Locked and set Sel to 0.
REQ-022 In LOCKED, Sel!=0 with FrameSync=1 SHALL discard the partial frame (no Valid), store the sample as slot 0, set Sel to 1, pulse SyncErr for one cycle and clear the miss count.
REQ-023 With Enable=0, all state, Sel, shadow registers and Out0-Out3 SHALL hold, and Valid and SyncErr SHALL be 0.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n=0, the block SHALL be in HUNT with Sel=0, Locked=0, Valid=0, SyncErr=0, Out0-Out3=0, shadow registers=0 and miss count=0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately, discard the partial frame, and produce no Valid.
REQ-027 After rst_n deasserts, the first edge SHALL follow HUNT rules.

Structure
REQ-028 The shared package/include SHALL hold the state encodings (HUNT=0, LOCKED=1), the slot count constant (4) and the slot index width (2).
REQ-029 Slot counting, wrap and miss-count logic SHALL live in one sub-module, tdm_slot_counter.
REQ-030 The FSM, shadow registers and output registers SHALL live in the top level.

Verification
REQ-031 Reset, then 4 Enable samples 0,1,0,1 with FrameSync on the first -> Out0..3=0,1,0,1, Valid pulses once, Locked=1, Sel=0.
REQ-032 Samples 1,1,1 in HUNT without FrameSync, then a frame 1,0,0,1 with FrameSync -> only 1,0,0,1 appears, and Valid pulses once.
REQ-033 While locked, FrameSync asserted at Sel=2 -> SyncErr pulses once, the previous Out values hold, and the next full frame is output correctly.
REQ-034 With MISS_MAX=2, two consecutive frame starts without FrameSync -> the first frame still outputs, the second start drops Locked and Sel=0.
REQ-035 Enable toggled 1,0,0,1,... within a frame -> Sel and Out hold during Enable=0, and the frame completes after 4 enabled samples.
REQ-036 rst_n pulled low at Sel=2 -> all outputs go to 0 asynchronously, and no Valid is produced for the partial frame.
